fifo_word_packer: RTL and testbench

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

---
 rtl/fifo_word_packer.sv | 149 ++++++++++++++
 tb/tb_fifo_word_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer
// Purpose  : Packs show-ahead FIFO entries into LANES-wide output words with
//            partial-word flush; optional idle auto-flush via macro
//            FIFO_PACKER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                        rclk,
    input  logic                        rrst,
    input  logic                        fifo_empty,
    input  logic [DATA_WIDTH-1:0]       fifo_data,
    output logic                        fifo_rd_en,
    input  logic                        flush,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_keep,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int c_idx_w = $clog2(LANES);
    localparam int c_cnt_w = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(LANES);

    logic [LANES-1:0][DATA_WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0]               r_fill_cnt;
    logic [LANES-1:0][DATA_WIDTH-1:0] r_out_data;
    logic [LANES-1:0]                 r_out_keep;
    logic                             r_out_valid;

    logic                             w_slot_free;
    logic                             w_acc_full;
    logic                             w_pop;
    logic                             w_flush_eff;
    logic [LANES-1:0][DATA_WIDTH-1:0] w_merged;
    logic [c_cnt_w-1:0]               w_cnt_after;
    logic [LANES-1:0][DATA_WIDTH-1:0] w_acc_nxt;
    logic [c_cnt_w-1:0]               w_cnt_nxt;
    logic                             w_load;
    logic [LANES-1:0][DATA_WIDTH-1:0] w_load_data;
    logic [LANES-1:0]                 w_load_keep;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_acc_full  = (r_fill_cnt == c_full);
    assign w_pop       = !fifo_empty && !rrst && (!w_acc_full || w_slot_free);
    assign fifo_rd_en  = w_pop;

`ifdef FIFO_PACKER_TIMEOUT_EN
    localparam int c_idle_w = $clog2(TIMEOUT + 1);
    localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TIMEOUT - 1);

    logic [c_idle_w-1:0] r_idle_cnt;
    logic                w_idle;
    logic                w_timeout;

    assign w_idle      = (r_fill_cnt != '0) && !w_pop;
    assign w_timeout   = w_idle && (r_idle_cnt == c_idle_max);
    assign w_flush_eff = flush || w_timeout;

    // Saturates at the trigger value so a blocked timeout keeps requesting.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_idle_cnt <= '0;
        end else if (!w_idle || flush || w_load) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != c_idle_max) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_flush_eff = flush;

    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        w_merged    = r_acc;
        w_cnt_after = r_fill_cnt;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_fill_cnt;
        w_load      = 1'b0;
        w_load_data = r_acc;
        w_load_keep = '0;

        if (w_acc_full) begin
            // A stalled full word leaves first; a concurrent pop starts the next one.
            if (w_slot_free) begin
                w_load      = 1'b1;
                w_load_keep = '1;
                w_load_data = r_acc;
                if (w_pop) begin
                    w_acc_nxt[0] = fifo_data;
                    w_cnt_nxt    = c_cnt_w'(1);
                end else begin
                    w_cnt_nxt    = '0;
                end
            end
        end else begin
            if (w_pop) begin
                w_merged[r_fill_cnt[c_idx_w-1:0]] = fifo_data;
            end
            w_cnt_after = r_fill_cnt + {{(c_cnt_w-1){1'b0}}, w_pop};
            w_acc_nxt   = w_merged;
            w_cnt_nxt   = w_cnt_after;

            if (w_slot_free && ((w_cnt_after == c_full) ||
                                (w_flush_eff && (w_cnt_after != '0)))) begin
                w_load    = 1'b1;
                w_cnt_nxt = '0;
                for (int i = 0; i < LANES; i++) begin
                    w_load_keep[i] = (c_cnt_w'(i) < w_cnt_after);
                    w_load_data[i] = w_load_keep[i] ? w_merged[i] : '0;
                end
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_acc       <= '0;
            r_fill_cnt  <= '0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_fill_cnt <= w_cnt_nxt;
            if (w_load) begin
                r_out_data  <= w_load_data;
                r_out_keep  <= w_load_keep;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_word_packer
// Purpose  : Directed and random stimulus for fifo_word_packer against a
//            queue-based word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

    localparam int DW  = 8;
    localparam int LN  = 4;
    localparam int TMO = 16;

    logic          rclk;
    logic          rrst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          flush;
    logic [31:0]   out_data;
    logic [3:0]    out_keep;
    logic          out_valid;
    logic          out_ready;

    fifo_word_packer #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .TIMEOUT    (TMO)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    int errors = 0;
    int checks = 0;

    logic [7:0]  fq[$];
    logic        hold;

    logic [7:0]  m_acc[$];
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    int          m_idle;

    logic        seen;
    int          seen_at;
    logic [31:0] seen_data;
    logic [3:0]  seen_keep;
    logic [31:0] held_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0) || hold;
        fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    // One clock: check the pop decision, advance the model, check outputs.
    task automatic tick();
        logic        sf, pop, fl, ld, nv, tmo;
        logic [31:0] nd;
        logic [3:0]  nk;
        logic [7:0]  nq[$];
        int          n;
`ifdef FIFO_PACKER_TIMEOUT_EN
        logic        idle;
`endif
        drive_fifo();
        #1;
        sf  = !m_valid || out_ready;
        pop = !rrst && !fifo_empty && ((m_acc.size() < LN) || sf);
        check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, pop});
        nq = m_acc;
        if (pop) nq.push_back(fifo_data);
`ifdef FIFO_PACKER_TIMEOUT_EN
        idle = (m_acc.size() != 0) && !pop;
        tmo  = idle && (m_idle == TMO - 1);
`else
        tmo  = 1'b0;
`endif
        fl = flush || tmo;
        ld = sf && ((nq.size() >= LN) || (fl && (nq.size() != 0)));
        nv = m_valid && !out_ready;
        nd = m_data;
        nk = m_keep;
        if (ld) begin
            n  = (nq.size() >= LN) ? LN : nq.size();
            nd = '0;
            nk = '0;
            for (int i = 0; i < n; i++) begin
                nd[8*i +: 8] = nq.pop_front();
                nk[i]        = 1'b1;
            end
            nv = 1'b1;
        end
        @(posedge rclk);
        if (rrst) begin
            m_acc.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_keep  = '0;
            m_idle  = 0;
        end else begin
            if (pop) void'(fq.pop_front());
            m_acc   = nq;
            m_valid = nv;
            m_data  = nd;
            m_keep  = nk;
`ifdef FIFO_PACKER_TIMEOUT_EN
            if (!idle || flush || ld) m_idle = 0;
            else if (m_idle != TMO - 1) m_idle++;
`endif
        end
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid || rrst) begin
            check("out_data", out_data, m_data);
            check("out_keep", {28'd0, out_keep}, {28'd0, m_keep});
        end
        drive_fifo();
    endtask

    initial begin
        m_valid = 1'b0; m_data = '0; m_keep = '0; m_idle = 0;
        hold = 1'b0; rrst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive_fifo();

        // Reset state
        tick(); tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_keep", {28'd0, out_keep}, 32'd0);
        rrst = 1'b0;

        // Streaming two full words
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i * 8'h11));
        for (int i = 0; i < 4; i++) tick();
        check("stream_w0", out_data, 32'h44332211);
        check("stream_k0", {28'd0, out_keep}, 32'hF);
        for (int i = 0; i < 4; i++) tick();
        check("stream_w1", out_data, 32'h88776655);
        check("stream_v1", {31'd0, out_valid}, 32'd1);

        // Partial flush, then flush with nothing accumulated
        fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b1;
        tick();
        check("flush_data", out_data, 32'h00A3A2A1);
        check("flush_keep", {28'd0, out_keep}, 32'h7);
        tick();
        check("empty_flush", {31'd0, out_valid}, 32'd0);
        tick();
        check("empty_flush2", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;

        // Back-pressure: accumulator fills behind a stalled word
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) fq.push_back(8'hB0 + 8'(i));
        for (int i = 0; i < 4; i++) tick();
        held_word = 32'hB3B2B1B0;
        check("stall_word", out_data, held_word);
        for (int i = 0; i < 5; i++) fq.push_back(8'hC0 + 8'(i));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", out_data, held_word);
        end
        check("stall_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("release_word", out_data, 32'hC3C2C1C0);
        check("release_pop", fq.size(), 32'd0);

        // Reset mid-stall with a pending word discards everything
        out_ready = 1'b0;
        fq.push_back(8'hD0); fq.push_back(8'hD1); fq.push_back(8'hD2);
        for (int i = 0; i < 3; i++) tick();
        rrst = 1'b1;
        fq.delete();
        tick();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_keep", {28'd0, out_keep}, 32'd0);
        rrst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(8'hE0 + 8'(i));
        for (int i = 0; i < 4; i++) tick();
        check("clean_word", out_data, 32'hE3E2E1E0);
        check("clean_keep", {28'd0, out_keep}, 32'hF);

        // Single byte left idle
        fq.push_back(8'h5A);
        tick();
        seen = 1'b0; seen_at = 0; seen_data = '0; seen_keep = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (out_valid && !seen) begin
                seen = 1'b1; seen_at = c; seen_data = out_data; seen_keep = out_keep;
            end
        end
`ifdef FIFO_PACKER_TIMEOUT_EN
        check("tmo_seen", {31'd0, seen}, 32'd1);
        check("tmo_cycles", seen_at, 32'd16);
        check("tmo_data", seen_data, 32'h0000005A);
        check("tmo_keep", {28'd0, seen_keep}, 32'h1);
`else
        check("no_tmo", {31'd0, seen}, 32'd0);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if (($urandom_range(0, 2) != 0) && (fq.size() < 8)) fq.push_back(8'($urandom));
            hold      = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
